// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: issues data-memory loads/stores over a
// req/ready handshake with timeout, formats store data/strobes and extends load data.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [31:0] pc_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic [1:0]  wb_sel_out,
    output logic [31:0] pc_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Anything that is not a byte or half access (including unknown encodings) is a word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3[1:0])
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        logic m;
        case (sz)
            SZ_H:    m = a[0];
            SZ_W:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] s;
        case (sz)
            SZ_B:    s = 4'b0001 << a;
            SZ_H:    s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // funct3[2] selects zero extension (BU/HU).
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = d >> {a, 3'b000};
        case (size_of(f3))
            SZ_B:    r = f3[2] ? {24'd0, shifted[7:0]}
                               : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    r = f3[2] ? {16'd0, shifted[15:0]}
                               : {{16{shifted[15]}}, shifted[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              access_s;
    logic [1:0]        size_s;
    logic              misaligned_s;
    logic              stall_s;

    assign access_s     = in_valid & (mem_read_in | mem_write_in);
    assign size_s       = size_of(funct3_in);
    assign misaligned_s = is_misaligned(size_s, alu_result_in[1:0]);

    // Next-state logic for the access FSM and its registered bus fields.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        f3_d        = f3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                cnt_d       = {CNT_W{1'b0}};
                err_d       = 1'b0;
                load_data_d = 32'd0;
                if (access_s && !misaligned_s) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = {alu_result_in[31:2], 2'b00};
                    wdata_d = mem_write_in ? store_wdata(size_s, store_data_in) : 32'd0;
                    wstrb_d = mem_write_in ? store_wstrb(size_s, alu_result_in[1:0]) : 4'b0000;
                    f3_d    = funct3_in;
                    off_d   = alu_result_in[1:0];
                end else begin
                    req_d = 1'b0;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    state_d     = DONE;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    wstrb_d     = 4'b0000;
                    cnt_d       = {CNT_W{1'b0}};
                    load_data_d = we_q ? 32'd0 : extend_load(f3_q, off_q, dmem_rdata);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    cnt_d   = {CNT_W{1'b0}};
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                wstrb_d = 4'b0000;
                cnt_d   = {CNT_W{1'b0}};
                err_d   = 1'b0;
            end
        endcase
    end

    // State and bus-field registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'b0000;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            load_data_q <= 32'd0;
            cnt_q       <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // MEM/WB-facing outputs: pass-through, bubble while stalled, result in DONE.
    always_comb begin
        alu_result_out = alu_result_in;
        rd_out         = rd_in;
        reg_write_out  = reg_write_in;
        wb_sel_out     = wb_sel_in;
        pc_out         = pc_in;
        mem_data_out   = 32'd0;
        stall_s        = 1'b0;
        misaligned_out = 1'b0;
        bus_err_out    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s && misaligned_s) begin
                    misaligned_out = 1'b1;
                    reg_write_out  = 1'b0;
                end else if (access_s) begin
                    stall_s       = 1'b1;
                    rd_out        = 5'd0;
                    reg_write_out = 1'b0;
                end else begin
                    stall_s = 1'b0;
                end
            end
            BUSY: begin
                stall_s       = 1'b1;
                rd_out        = 5'd0;
                reg_write_out = 1'b0;
            end
            DONE: begin
                if (err_q) begin
                    bus_err_out   = 1'b1;
                    reg_write_out = 1'b0;
                end else begin
                    mem_data_out = load_data_q;
                end
            end
            default: begin
                rd_out        = 5'd0;
                reg_write_out = 1'b0;
            end
        endcase
    end

    // Reset must release the upstream freeze at once, not at the next edge.
    assign stall_out  = stall_s & ~reset;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;

endmodule
